// File: rtl/nist_bit_sampler.sv
// Front end of the NIST randomness core: synchronises external bit/strobe/start
// pins and frames exactly 2^SEQ_LEN_LOG2 sampled bits as single-cycle pulses.
module nist_bit_sampler #(
    parameter int unsigned SEQ_LEN_LOG2 = 7,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    input  logic                  bit_in,
    input  logic                  strobe_in,
    input  logic                  start_in,
    output logic                  bit_out,
    output logic                  bit_valid,
    output logic                  seq_first,
    output logic                  seq_last,
    output logic [SEQ_LEN_LOG2:0] seq_count,
    output logic                  busy,
    output logic                  seq_done,
    output logic                  stray
);

    localparam int unsigned      CNT_W    = SEQ_LEN_LOG2 + 1;
    localparam int unsigned      SYNC_MSB = SYNC_STAGES - 1;
    localparam logic [CNT_W-1:0] SEQ_N    = CNT_W'(1) << SEQ_LEN_LOG2;
    localparam logic [CNT_W-1:0] SEQ_LAST = SEQ_N - CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] r_bit_sync;
    logic [SYNC_STAGES-1:0] r_strb_sync;
    logic [SYNC_STAGES-1:0] r_start_sync;
    logic                   r_strb_prev;
    logic                   r_start_prev;

    state_t                 r_state;
    state_t                 w_next_state;
    logic                   r_bit_out;
    logic                   r_bit_valid;
    logic                   r_seq_first;
    logic                   r_seq_last;
    logic [CNT_W-1:0]       r_count;
    logic                   r_busy;
    logic                   r_seq_done;
    logic                   r_stray;

    logic                   w_strb_edge;
    logic                   w_start_edge;
    logic                   w_bit;
    logic                   w_bit_out;
    logic                   w_bit_valid;
    logic                   w_seq_first;
    logic                   w_seq_last;
    logic [CNT_W-1:0]       w_count;
    logic                   w_stray;

    // Input synchronisers plus one history flop per edge-detected signal
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_sync   <= '0;
            r_strb_sync  <= '0;
            r_start_sync <= '0;
            r_strb_prev  <= 1'b0;
            r_start_prev <= 1'b0;
        end else begin
            r_bit_sync   <= {r_bit_sync[SYNC_STAGES-2:0], bit_in};
            r_strb_sync  <= {r_strb_sync[SYNC_STAGES-2:0], strobe_in};
            r_start_sync <= {r_start_sync[SYNC_STAGES-2:0], start_in};
            r_strb_prev  <= r_strb_sync[SYNC_MSB];
            r_start_prev <= r_start_sync[SYNC_MSB];
        end
    end

    assign w_strb_edge  = ena & r_strb_sync[SYNC_MSB] & ~r_strb_prev;
    assign w_start_edge = ena & r_start_sync[SYNC_MSB] & ~r_start_prev;
    assign w_bit        = r_bit_sync[SYNC_MSB];

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_bit_out   <= 1'b0;
            r_bit_valid <= 1'b0;
            r_seq_first <= 1'b0;
            r_seq_last  <= 1'b0;
            r_count     <= '0;
            r_busy      <= 1'b0;
            r_seq_done  <= 1'b0;
            r_stray     <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_bit_out   <= w_bit_out;
            r_bit_valid <= w_bit_valid;
            r_seq_first <= w_seq_first;
            r_seq_last  <= w_seq_last;
            r_count     <= w_count;
            r_busy      <= (w_next_state == ST_RUN);
            r_seq_done  <= (w_next_state == ST_DONE);
            r_stray     <= w_stray;
        end
    end

    // Next state; a start edge always wins over a coincident strobe edge
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (w_start_edge) w_next_state = ST_RUN;
            ST_RUN: begin
                if (w_start_edge)
                    w_next_state = ST_RUN;
                else if (w_strb_edge && (r_count == SEQ_LAST))
                    w_next_state = ST_DONE;
            end
            ST_DONE: if (w_start_edge) w_next_state = ST_RUN;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Next values of the pulse, count and stray outputs
    always_comb begin
        w_bit_out   = r_bit_out;
        w_bit_valid = 1'b0;
        w_seq_first = 1'b0;
        w_seq_last  = 1'b0;
        w_count     = r_count;
        w_stray     = r_stray;
        if (w_start_edge) begin
            w_count = '0;
            w_stray = 1'b0;
        end else if (w_strb_edge) begin
            if (r_state == ST_RUN) begin
                w_bit_out   = w_bit;
                w_bit_valid = 1'b1;
                w_seq_first = (r_count == '0);
                w_seq_last  = (r_count == SEQ_LAST);
                w_count     = r_count + CNT_W'(1);
            end else begin
                w_stray = 1'b1;
            end
        end
    end

    assign bit_out   = r_bit_out;
    assign bit_valid = r_bit_valid;
    assign seq_first = r_seq_first;
    assign seq_last  = r_seq_last;
    assign seq_count = r_count;
    assign busy      = r_busy;
    assign seq_done  = r_seq_done;
    assign stray     = r_stray;

endmodule

// File: tb/tb_nist_bit_sampler.sv
// Directed self-checking bench for nist_bit_sampler at default parameters.
module tb_nist_bit_sampler;

    localparam int unsigned LOG2 = 7;
    localparam int          N    = 128;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ena = 1'b1;
    logic        bit_in = 1'b0;
    logic        strobe_in = 1'b0;
    logic        start_in = 1'b0;
    logic        bit_out, bit_valid, seq_first, seq_last, busy, seq_done, stray;
    logic [LOG2:0] seq_count;

    int errors = 0;
    int checks = 0;

    logic q_bit[$];
    logic q_first[$];
    logic q_last[$];

    nist_bit_sampler #(.SEQ_LEN_LOG2(LOG2), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .bit_in(bit_in),
        .strobe_in(strobe_in), .start_in(start_in), .bit_out(bit_out),
        .bit_valid(bit_valid), .seq_first(seq_first), .seq_last(seq_last),
        .seq_count(seq_count), .busy(busy), .seq_done(seq_done), .stray(stray)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bit_valid === 1'b1) begin
            q_bit.push_back(bit_out);
            q_first.push_back(seq_first);
            q_last.push_back(seq_last);
        end
    end

    task automatic send_bit(input logic b);
        @(negedge clk) bit_in = b;
        @(negedge clk) strobe_in = 1'b1;
        repeat (2) @(negedge clk);
        strobe_in = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_start();
        @(negedge clk) start_in = 1'b1;
        repeat (2) @(negedge clk);
        start_in = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0; ena = 1'b1; bit_in = 1'b0; strobe_in = 1'b0; start_in = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        #12;
        checks++; if (seq_count !== '0) begin errors++; $display("FAIL reset_count got=%0d exp=0", seq_count); end
        checks++; if ({bit_out, bit_valid, seq_first, seq_last} !== 4'b0) begin errors++; $display("FAIL reset_pulses got=%b exp=0000", {bit_out, bit_valid, seq_first, seq_last}); end
        checks++; if ({busy, seq_done, stray} !== 3'b0) begin errors++; $display("FAIL reset_status got=%b exp=000", {busy, seq_done, stray}); end
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_full_seq();
        int base, bad, nfirst, nlast;
        send_start();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL full_busy_start got=%b exp=1", busy); end
        checks++; if (seq_count !== '0) begin errors++; $display("FAIL full_count_start got=%0d exp=0", seq_count); end
        base = q_bit.size();
        for (int i = 0; i < N; i++) send_bit((i % 2) == 0);
        checks++; if (q_bit.size() - base != N) begin errors++; $display("FAIL full_pulses got=%0d exp=%0d", q_bit.size() - base, N); end
        bad = 0; nfirst = 0; nlast = 0;
        for (int j = base; j < q_bit.size(); j++) begin
            if (q_bit[j] !== ((((j - base) % 2) == 0) ? 1'b1 : 1'b0)) bad++;
            if (q_first[j] === 1'b1) nfirst++;
            if (q_last[j] === 1'b1) nlast++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL full_bits got=%0d bad exp=0", bad); end
        checks++; if (nfirst != 1 || q_first[base] !== 1'b1) begin errors++; $display("FAIL full_first got=%0d exp=1 at pulse 0", nfirst); end
        checks++; if (nlast != 1 || q_last[base + N - 1] !== 1'b1) begin errors++; $display("FAIL full_last got=%0d exp=1 at pulse 127", nlast); end
        checks++; if (seq_count !== 8'd128) begin errors++; $display("FAIL full_count got=%0d exp=128", seq_count); end
        checks++; if ({seq_done, busy, stray} !== 3'b100) begin errors++; $display("FAIL full_status got=%b exp=100", {seq_done, busy, stray}); end
    endtask

    task automatic test_latency();
        apply_reset();
        send_start();
        @(negedge clk) bit_in = 1'b1;
        @(negedge clk) strobe_in = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            checks++; if (bit_valid !== (c == 3)) begin errors++; $display("FAIL latency_valid_c%0d got=%b exp=%b", c, bit_valid, (c == 3)); end
            if (c == 3) begin
                checks++; if ({bit_out, seq_first, seq_last} !== 3'b110) begin errors++; $display("FAIL latency_flags got=%b exp=110", {bit_out, seq_first, seq_last}); end
            end
            if (c == 2) strobe_in = 1'b0;
        end
        checks++; if (seq_count !== 8'd1) begin errors++; $display("FAIL latency_count got=%0d exp=1", seq_count); end
    endtask

    task automatic test_stray();
        int base;
        apply_reset();
        base = q_bit.size();
        send_bit(1'b1);
        checks++; if (q_bit.size() != base) begin errors++; $display("FAIL stray_idle_pulse got=%0d exp=0", q_bit.size() - base); end
        checks++; if ({stray, busy} !== 2'b10) begin errors++; $display("FAIL stray_idle_flag got=%b exp=10", {stray, busy}); end
        send_start();
        checks++; if ({stray, busy} !== 2'b01 || seq_count !== '0) begin errors++; $display("FAIL stray_clear1 got=%b cnt=%0d exp=01 cnt=0", {stray, busy}, seq_count); end
        for (int i = 0; i < N; i++) send_bit(i % 2);
        base = q_bit.size();
        send_bit(1'b0);
        checks++; if (q_bit.size() != base) begin errors++; $display("FAIL stray_done_pulse got=%0d exp=0", q_bit.size() - base); end
        checks++; if ({stray, seq_done} !== 2'b11 || seq_count !== 8'd128) begin errors++; $display("FAIL stray_done_flag got=%b cnt=%0d exp=11 cnt=128", {stray, seq_done}, seq_count); end
        send_start();
        checks++; if ({stray, busy, seq_done} !== 3'b010 || seq_count !== '0) begin errors++; $display("FAIL stray_clear2 got=%b cnt=%0d exp=010 cnt=0", {stray, busy, seq_done}, seq_count); end
    endtask

    task automatic test_restart();
        int base, drops, nfirst, nlast;
        for (int i = 0; i < 50; i++) send_bit((i % 2) == 0);
        checks++; if (seq_count !== 8'd50) begin errors++; $display("FAIL restart_count50 got=%0d exp=50", seq_count); end
        drops = 0;
        @(negedge clk) start_in = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (busy !== 1'b1) drops++;
            if (c == 2) start_in = 1'b0;
        end
        checks++; if (drops != 0 || seq_count !== '0) begin errors++; $display("FAIL restart_hold got drops=%0d cnt=%0d exp drops=0 cnt=0", drops, seq_count); end
        base = q_bit.size();
        for (int i = 0; i < N; i++) send_bit((i % 2) == 0);
        nfirst = 0; nlast = 0;
        for (int j = base; j < q_bit.size(); j++) begin
            if (q_first[j] === 1'b1) nfirst++;
            if (q_last[j] === 1'b1) nlast++;
        end
        checks++; if (nfirst != 1 || q_first[base] !== 1'b1) begin errors++; $display("FAIL restart_first got=%0d exp=1 at new pulse 0", nfirst); end
        checks++; if (nlast != 1 || q_last[base + N - 1] !== 1'b1) begin errors++; $display("FAIL restart_last got=%0d exp=1 at new pulse 127", nlast); end
        checks++; if (seq_done !== 1'b1 || seq_count !== 8'd128) begin errors++; $display("FAIL restart_done got=%b cnt=%0d exp=1 cnt=128", seq_done, seq_count); end
    endtask

    task automatic test_simultaneous();
        int base;
        send_start();
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        checks++; if (seq_count !== 8'd5) begin errors++; $display("FAIL simul_pre got=%0d exp=5", seq_count); end
        base = q_bit.size();
        @(negedge clk) begin start_in = 1'b1; strobe_in = 1'b1; end
        repeat (2) @(negedge clk);
        start_in = 1'b0; strobe_in = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (q_bit.size() != base) begin errors++; $display("FAIL simul_pulse got=%0d exp=0", q_bit.size() - base); end
        checks++; if (seq_count !== '0 || {stray, busy} !== 2'b01) begin errors++; $display("FAIL simul_state got cnt=%0d flags=%b exp cnt=0 flags=01", seq_count, {stray, busy}); end
    endtask

    task automatic test_ena_and_reset();
        int base;
        for (int i = 0; i < 10; i++) send_bit((i % 2) == 0);
        base = q_bit.size();
        @(negedge clk) ena = 1'b0;
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        @(negedge clk) ena = 1'b1;
        checks++; if (q_bit.size() != base || seq_count !== 8'd10) begin errors++; $display("FAIL ena_freeze got pulses=%0d cnt=%0d exp 0 cnt=10", q_bit.size() - base, seq_count); end
        send_bit(1'b1);
        checks++; if (q_bit.size() != base + 1 || seq_count !== 8'd11) begin errors++; $display("FAIL ena_resume got pulses=%0d cnt=%0d exp 1 cnt=11", q_bit.size() - base, seq_count); end
        checks++; if (bit_out !== 1'b1) begin errors++; $display("FAIL ena_bit got=%b exp=1", bit_out); end
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks++; if ({bit_out, bit_valid, seq_first, seq_last, busy, seq_done, stray} !== 7'b0) begin errors++; $display("FAIL async_reset_flags got=%b exp=0000000", {bit_out, bit_valid, seq_first, seq_last, busy, seq_done, stray}); end
        checks++; if (seq_count !== '0) begin errors++; $display("FAIL async_reset_count got=%0d exp=0", seq_count); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if ({busy, seq_done, stray} !== 3'b000 || seq_count !== '0) begin errors++; $display("FAIL post_reset got=%b cnt=%0d exp=000 cnt=0", {busy, seq_done, stray}, seq_count); end
    endtask

    initial begin
        test_reset();
        test_full_seq();
        test_latency();
        test_stray();
        test_restart();
        test_simultaneous();
        test_ena_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
